serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- It reuses a single one-bit full-subtractor cell and a registered borrow, so one cell is shared across all bit positions.
- Start/busy/done handshake; the result is held stable until the next accepted start.
- It is the subtract-direction counterpart of the team's ripple adders, used where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is 2 or more.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse in DONE.
- diff  output  WIDTH  result; valid from done onward and held until the next accepted start.
- borrow_out  output  1  final borrow; 1 means a < b unsigned. Valid and held like diff.

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy=0, done=0, diff=0, borrow_out=0.
  - Internal shift registers, borrow flop and counter are cleared.
  - Reset has priority over all other inputs in every state, including mid-RUN; a partial result is discarded.
- State IDLE:
  - If start=1 at an edge: load a_sh<=a, b_sh<=b, brw<=0, cnt<=0, clear diff and borrow_out, go to RUN.
  - Otherwise hold.
- State RUN, at each edge:
  - Full-subtractor inputs: x=a_sh[0], y=b_sh[0], bin=brw.
  - d = x^y^bin.
  - bout = (~x&y) | (~(x^y)&bin).
  - Shift a_sh and b_sh right by one.
  - Shift d into the MSB of the diff shift register.
  - brw<=bout; cnt<=cnt+1.
  - When cnt==WIDTH-1: go to DONE and latch borrow_out<=bout.
  - RUN therefore lasts exactly WIDTH cycles.
  - cnt width is $clog2(WIDTH); the counter never wraps in normal operation.
- State DONE:
  - done=1 for exactly one cycle, then unconditionally go to IDLE.
  - diff and borrow_out stay stable.
- Latency: for start sampled at edge E, busy is high from E+1 through E+WIDTH, and done is high in the cycle after edge E+WIDTH.
- Next operation: the earliest next start is accepted at the edge ending the DONE cycle + 1 (i.e. in IDLE).
- start while RUN or DONE: ignored, with no queuing; a and b changes during RUN have no effect.
- Arithmetic: modulo 2^WIDTH. borrow_out equals the inverted carry of a + ~b + 1.

Optional Feature:
- Macro: SERIAL_SUB_OVERFLOW_EN.
- When defined:
  - Extra output port ovf (1 bit), which is the two's-complement signed overflow.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
  - Latched with borrow_out, reset to 0, held like diff.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package serial_sub_pkg:
  - state_t enum {IDLE, RUN, DONE} as 2-bit logic.
  - Localparam helper for counter width.
- Sub-module fullsubtractor (inputs x, y, bin; outputs d, bout): purely combinational, instantiated once.
- Top module: FSM, shift registers, borrow flop, counter.

Test Plan (WIDTH=8):
- a=0x05, b=0x03, start pulse -> busy 8 cycles, done pulse 9 cycles after the start edge, diff=0x02, borrow_out=0.
- a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; a=0x00, b=0x00 -> diff=0x00, borrow_out=0; a=0x00, b=0xFF -> diff=0x01, borrow_out=1.
- Start 0xFF-0x01, then re-assert start and change a/b at RUN cycle 3 -> ignored; diff=0xFE, a single done pulse, and a later start in IDLE is accepted.
- Assert reset at RUN cycle 4 -> next cycle busy=0, done=0, diff=0, borrow_out=0, state IDLE; no done pulse follows.
- With SERIAL_SUB_OVERFLOW_EN defined:
  - a=0x80, b=0x01 -> diff=0x7F, ovf=1, borrow_out=0.
  - a=0x7F, b=0xFF -> diff=0x80, ovf=1, borrow_out=1.
  - a=0x10, b=0x01 -> ovf=0.
- Randomized 500 back-to-back operations against a reference model (a-b mod 256; borrow = a<b) -> zero mismatches, and done spacing ≥ WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bit-position counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fullsubtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module fullsubtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             borrow_out
);

  localparam int unsigned    CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fs_d, fs_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf_q, ovf_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
`endif

  // Single shared cell, fed from the operand LSBs and the registered borrow.
  fullsubtractor u_fs (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (brw_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    brw_d    = brw_q;
    borrow_d = borrow_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
    ovf_d    = ovf_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          brw_d    = 1'b0;
          cnt_d    = '0;
          diff_d   = '0;
          borrow_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
          ovf_d    = 1'b0;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        diff_d = {fs_d, diff_q[WIDTH-1:1]};
        brw_d  = fs_bout;
        busy_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Last bit: the cell's borrow is the final borrow, fs_d is the result MSB.
          borrow_d = fs_bout;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
          ovf_d    = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      brw_q    <= brw_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8); checks ovf when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .ovf        (ovf),
`endif
    .borrow_out (borrow_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation; glitch>0 re-asserts start with new operands in that RUN cycle.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int glitch);
    int          ad, bd, sd, busy_cnt;
    logic [7:0]  ed;
    logic        eb;
    ad = int'(av);
    bd = int'(bv);
    ed = 8'((ad - bd + 256) % 256);
    eb = (ad < bd);
    sd = int'($signed(av)) - int'($signed(bv));
    a = av;
    b = bv;
    start = 1'b1;
    step();
    start = 1'b0;
    busy_cnt = 0;
    for (int k = 1; k <= int'(W); k++) begin
      if (busy && !done) busy_cnt++;
      if (k == glitch) begin
        start = 1'b1;
        a = 8'($urandom);
        b = 8'($urandom);
      end
      step();
      start = 1'b0;
    end
    check("busy_cycles", 32'(busy_cnt), 32'(W));
    check("done_pulse", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("diff", 32'(diff), 32'(ed));
    check("borrow_out", 32'(borrow_out), 32'(eb));
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("ovf", 32'(ovf), 32'((sd > 127) || (sd < -128)));
`endif
    done_cyc = cyc;
    step();
    check("done_single", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("diff_hold", 32'(diff), 32'(ed));
    check("borrow_hold", 32'(borrow_out), 32'(eb));
  endtask

  initial begin
    int pulses;
    int prev_done;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    reset = 1'b0;
    step();

    run_op(8'h05, 8'h03, 0);
    run_op(8'h03, 8'h05, 0);
    run_op(8'h00, 8'h00, 0);
    run_op(8'h00, 8'hFF, 0);
    run_op(8'hFF, 8'h01, 3);
    run_op(8'h80, 8'h01, 0);
    run_op(8'h7F, 8'hFF, 0);
    run_op(8'h10, 8'h01, 0);

    // Reset asserted during RUN cycle 4 discards the partial result.
    a = 8'hA5;
    b = 8'h3C;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("midrun_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_diff", 32'(diff), 32'd0);
    check("mrst_borrow", 32'(borrow_out), 32'd0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (done || busy) pulses++;
      step();
    end
    check("mrst_no_activity", 32'(pulses), 32'd0);

    // Back-to-back random operations.
    run_op(8'($urandom), 8'($urandom), 0);
    for (int n = 1; n < 500; n++) begin
      prev_done = done_cyc;
      run_op(8'($urandom), 8'($urandom), 0);
      check("done_spacing", 32'(done_cyc - prev_done >= int'(W) + 2), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
